// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned DBITS_DEF       = 32;
  localparam logic [31:0] START_PC_DEF    = 32'h40;
  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam logic [31:0] ALIGN_MASK      = ~32'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_reg.sv
// Shared Register block: width-parameterised register with write enable and
// synchronous active-high reset to a configurable value.
module fetch_ctrl_reg #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_q <= RESET_VALUE;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to
// instruction memory and hands words to decode, squashing stale fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      DBITS       = DBITS_DEF,
  parameter logic [DBITS-1:0] START_PC    = DBITS'(START_PC_DEF),
  parameter int unsigned      INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirectPc,
  output logic             imemReq,
  output logic [DBITS-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [DBITS-1:0] imemData,
  output logic             instrValid,
  input  logic             instrReady,
  output logic [DBITS-1:0] instr,
  output logic [DBITS-1:0] instrPc,
  output logic [DBITS-1:0] fetchPc,
  output fetch_state_e     dbgState
);

  // Handshakes: imemReq/imemAddr stay put until the one-cycle imemAck, and an
  // ack seen while imemReq is low is ignored. instrValid/instr/instrPc hold
  // until instrReady; a word moves only on instrValid & instrReady w/o redirect.

  localparam logic [DBITS-1:0] ALIGN = {{(DBITS-2){1'b1}}, 2'b00};
  localparam logic [DBITS-1:0] INC   = DBITS'(INSTR_BYTES);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [DBITS-1:0] w_pc;
  logic [DBITS-1:0] w_req_addr;
  logic [DBITS-1:0] w_pc_d;
  logic [DBITS-1:0] w_req_d;
  logic [DBITS-1:0] w_redir_pc;
  logic             w_pc_we;
  logic             w_req_we;
  logic             w_load;
  logic             w_valid_nxt;

  logic [DBITS-1:0] r_instr;
  logic [DBITS-1:0] r_instr_pc;
  logic             r_instr_valid;

  assign w_redir_pc = redirectPc & ALIGN;

  fetch_ctrl_reg #(
    .WIDTH      (DBITS),
    .RESET_VALUE(START_PC)
  ) u_pc (
    .i_clk(clk),
    .i_res(res),
    .i_we (w_pc_we),
    .i_d  (w_pc_d),
    .o_q  (w_pc)
  );

  fetch_ctrl_reg #(
    .WIDTH      (DBITS),
    .RESET_VALUE(START_PC)
  ) u_req_addr (
    .i_clk(clk),
    .i_res(res),
    .i_we (w_req_we),
    .i_d  (w_req_d),
    .o_q  (w_req_addr)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_pc_d      = w_pc;
    w_req_we    = 1'b0;
    w_req_d     = w_pc;
    w_load      = 1'b0;
    w_valid_nxt = r_instr_valid;

    // Redirect outranks every other event: new PC, nothing held survives.
    if (redirect) begin
      w_pc_we     = 1'b1;
      w_pc_d      = w_redir_pc;
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        w_req_we    = 1'b1;
        w_req_d     = redirect ? w_redir_pc : w_pc;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          if (imemAck) begin
            w_req_we = 1'b1;
            w_req_d  = w_redir_pc;
          end else begin
            // Address may not move mid-request; wait out the old one.
            w_state_nxt = DRAIN;
          end
        end else if (imemAck) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_pc_we     = 1'b1;
          w_pc_d      = w_req_addr + INC;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_req_we    = 1'b1;
          w_req_d     = w_redir_pc;
          w_state_nxt = FETCH;
        end else if (instrReady) begin
          w_valid_nxt = 1'b0;
          w_req_we    = 1'b1;
          w_req_d     = w_pc;
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (imemAck) begin
          w_req_we    = 1'b1;
          w_req_d     = redirect ? w_redir_pc : w_pc;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= w_valid_nxt;
      if (w_load) begin
        r_instr    <= imemData;
        r_instr_pc <= w_req_addr;
      end
    end
  end

  assign imemReq    = (r_state == FETCH) || (r_state == DRAIN);
  assign imemAddr   = w_req_addr;
  assign fetchPc    = w_pc;
  assign instrValid = r_instr_valid;
  assign instr      = r_instr;
  assign instrPc    = r_instr_pc;
  assign dbgState   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, a short reset sequence, then
// randomized traffic checked against a program-order delivery model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] START = 32'h40;

  logic         clk = 1'b0;
  logic         res;
  logic         redirect;
  logic [W-1:0] redirectPc;
  logic         imemReq;
  logic [W-1:0] imemAddr;
  logic         imemAck;
  logic [W-1:0] imemData;
  logic         instrValid;
  logic         instrReady;
  logic [W-1:0] instr;
  logic [W-1:0] instrPc;
  logic [W-1:0] fetchPc;
  fetch_state_e dbgState;

  fetch_ctrl dut (
    .clk       (clk),
    .res       (res),
    .redirect  (redirect),
    .redirectPc(redirectPc),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemData  (imemData),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .instr     (instr),
    .instrPc   (instrPc),
    .fetchPc   (fetchPc),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rs;
    logic         rd;
    logic [W-1:0] rpc;
    logic         ak;
    logic         rdy;
    logic         e_req;
    logic [W-1:0] e_addr;
    logic         e_valid;
    logic [W-1:0] e_ipc;
    logic [W-1:0] e_fpc;
  } vec_t;

  vec_t vt[$];

  // Memory contents: a fixed hash of the word address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rs, input logic rd, input logic [W-1:0] rpc,
                     input logic ak, input logic rdy, input logic er,
                     input logic [W-1:0] ea, input logic ev,
                     input logic [W-1:0] eip, input logic [W-1:0] efp);
    vec_t v;
    v = '{rs, rd, rpc, ak, rdy, er, ea, ev, eip, efp};
    vt.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rs, input logic rd, input logic [W-1:0] rpc,
                       input logic ak, input logic rdy);
    res        = rs;
    redirect   = rd;
    redirectPc = rpc;
    imemAck    = ak;
    instrReady = rdy;
    imemData   = imemReq ? mem_word(imemAddr) : $urandom;
  endtask

  task automatic fill_table();
    // rows: res redir rpc ack rdy | req addr valid instrPc fetchPc
    add(0,0,0,           0,1, 0,32'h40,0,32'h0,32'h40);        // reset state
    add(0,0,0,           1,1, 1,32'h40,0,32'h0,32'h40);
    add(0,0,0,           0,1, 0,32'h40,1,32'h40,32'h44);
    add(0,0,0,           1,1, 1,32'h44,0,32'h40,32'h44);
    add(0,0,0,           0,1, 0,32'h44,1,32'h44,32'h48);
    add(0,0,0,           0,0, 1,32'h48,0,32'h44,32'h48);       // 2-cycle latency
    add(0,0,0,           1,0, 1,32'h48,0,32'h44,32'h48);
    add(0,0,0,           0,0, 0,32'h48,1,32'h48,32'h4C);       // back-pressure
    add(0,0,0,           1,0, 0,32'h48,1,32'h48,32'h4C);       // stray ack ignored
    add(0,0,0,           0,0, 0,32'h48,1,32'h48,32'h4C);
    add(0,0,0,           0,0, 0,32'h48,1,32'h48,32'h4C);
    add(0,0,0,           0,0, 0,32'h48,1,32'h48,32'h4C);
    add(0,0,0,           0,1, 0,32'h48,1,32'h48,32'h4C);
    add(0,0,0,           1,1, 1,32'h4C,0,32'h48,32'h4C);
    add(0,1,32'h103,     0,1, 0,32'h4C,1,32'h4C,32'h50);       // redirect in HOLD
    add(0,1,32'h200,     0,0, 1,32'h100,0,32'h4C,32'h100);     // redirect mid-request
    add(0,0,0,           0,0, 1,32'h100,0,32'h4C,32'h200);
    add(0,1,32'h300,     0,0, 1,32'h100,0,32'h4C,32'h200);     // second redirect in DRAIN
    add(0,0,0,           1,0, 1,32'h100,0,32'h4C,32'h300);
    add(0,1,32'h500,     1,0, 1,32'h300,0,32'h4C,32'h300);     // redirect + ack
    add(0,1,32'hFFFFFFFF,1,0, 1,32'h500,0,32'h4C,32'h500);
    add(0,0,0,           1,0, 1,32'hFFFFFFFC,0,32'h4C,32'hFFFFFFFC);
    add(0,0,0,           0,1, 0,32'hFFFFFFFC,1,32'hFFFFFFFC,32'h0);   // wrap
    add(0,1,32'h80,      0,0, 1,32'h0,0,32'hFFFFFFFC,32'h0);
    add(1,0,0,           1,0, 1,32'h0,0,32'hFFFFFFFC,32'h80);  // reset mid-DRAIN
    add(1,0,0,           1,0, 0,32'h40,0,32'h0,32'h40);
    add(0,0,0,           1,0, 0,32'h40,0,32'h0,32'h40);        // ack in IDLE ignored
    add(0,0,0,           1,0, 1,32'h40,0,32'h0,32'h40);
    add(0,0,0,           0,1, 0,32'h40,1,32'h40,32'h44);
  endtask

  // ---------------- test ----------------
  logic         stab_pending;
  logic [W-1:0] stab_addr;
  logic [W-1:0] exp_pc;
  logic [W-1:0] rpc;

  initial begin
    res = 1'b1; redirect = 1'b0; redirectPc = '0;
    imemAck = 1'b0; instrReady = 1'b0; imemData = '0;
    fill_table();
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Table: compare current outputs, then apply the row's inputs.
    foreach (vt[i]) begin
      check($sformatf("v%0d.req", i),     32'(imemReq),    32'(vt[i].e_req));
      check($sformatf("v%0d.addr", i),    imemAddr,        vt[i].e_addr);
      check($sformatf("v%0d.valid", i),   32'(instrValid), 32'(vt[i].e_valid));
      check($sformatf("v%0d.instrPc", i), instrPc,         vt[i].e_ipc);
      check($sformatf("v%0d.fetchPc", i), fetchPc,         vt[i].e_fpc);
      check($sformatf("v%0d.instr", i),   instr,
            (vt[i].e_ipc == 0) ? 32'h0 : mem_word(vt[i].e_ipc));
      drive(vt[i].rs, vt[i].rd, vt[i].rpc, vt[i].ak, vt[i].rdy);
      @(negedge clk);
    end

    // Hand sequence: fetch 0x44 in 1 cycle, then reset while it is held.
    check("hs.addr", imemAddr, 32'h44);
    check("hs.req", 32'(imemReq), 32'h1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    check("hs.valid", 32'(instrValid), 32'h1);
    check("hs.instr", instr, mem_word(32'h44));
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    check("hs.rst_valid", 32'(instrValid), 32'h0);
    check("hs.rst_req", 32'(imemReq), 32'h0);
    check("hs.rst_instr", instr, 32'h0);
    check("hs.rst_instrPc", instrPc, 32'h0);
    check("hs.rst_fetchPc", fetchPc, START);
    check("hs.rst_state", 32'(dbgState), 32'(IDLE));

    // Random traffic: delivered words must follow program order from the
    // last reset/redirect, and a pending request must never move.
    exp_q.delete();
    exp_q.push_back(START);
    stab_pending = 1'b0;
    stab_addr    = '0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stab_pending) begin
        check("rnd.req_held", 32'(imemReq), 32'h1);
        check("rnd.addr_held", imemAddr, stab_addr);
      end
      check("rnd.valid_vs_req", 32'(instrValid && imemReq), 32'h0);
      if (instrValid) check("rnd.fetchPc", fetchPc, instrPc + 32'd4);

      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) == 0),
            rpc,
            imemReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)));

      if (res) begin
        exp_q.delete();
        exp_q.push_back(START);
      end else if (redirect) begin
        exp_q.delete();
        exp_q.push_back(redirectPc & ~32'h3);
      end else if (instrValid && instrReady) begin
        exp_pc = exp_q.pop_front();
        check("rnd.instrPc", instrPc, exp_pc);
        check("rnd.instr", instr, mem_word(exp_pc));
        deliveries++;
        exp_q.push_back(exp_pc + 32'd4);
      end
      stab_pending = imemReq && !imemAck && !res;
      stab_addr    = imemAddr;
      @(negedge clk);
    end
    check("rnd.progress", 32'(deliveries >= 50), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
